// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
//
// Instruction fetch stage for the 5-stage MIPS pipeline. A small prefetch
// queue sits between instruction memory and decode so that fetch can keep
// running ahead while decode is stalled. A taken branch/jump flushes the
// queue and restarts fetch at the (word-aligned) target.
//
// Ports:
//   clk          single clock, all state changes on its rising edge
//   rst          synchronous active-high reset (pc, queue; not imem)
//   stall        decode not ready; the head entry is held
//   redirect     taken branch/jump from the memory stage
//   redirect_pc  branch/jump target (low two bits ignored)
//   imem_we      instruction memory write enable (loader)
//   imem_waddr   word address for the write
//   imem_wdata   word to write
//   d_valid      head entry valid
//   d_inst       head instruction, 0 (nop) when empty
//   d_pc         head PC+4, 0 when empty
//   q_count      current queue occupancy
module fetch_queue_unit #(
  parameter int                DATA_W     = 32,
  parameter int                IMEM_DEPTH = 32,
  parameter int                QDEPTH     = 4,
  parameter logic [DATA_W-1:0] RESET_PC   = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall,
  input  logic                           redirect,
  input  logic [DATA_W-1:0]              redirect_pc,
  input  logic                           imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0]  imem_waddr,
  input  logic [DATA_W-1:0]              imem_wdata,
  output logic                           d_valid,
  output logic [DATA_W-1:0]              d_inst,
  output logic [DATA_W-1:0]              d_pc,
  output logic [$clog2(QDEPTH+1)-1:0]    q_count
);

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH+1);

  logic [DATA_W-1:0] imem   [IMEM_DEPTH];
  logic [DATA_W-1:0] inst_q [QDEPTH];
  logic [DATA_W-1:0] pc4_q  [QDEPTH];

  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] pc_plus4;
  logic [DATA_W-1:0] fetch_word;
  logic [DATA_W-1:0] target_pc;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic              push;
  logic              pop;

  // PC arithmetic wraps modulo 2^DATA_W; fetch index wraps modulo the
  // memory size simply by taking the word-address bits.
  assign pc_plus4   = pc + DATA_W'(4);
  assign fetch_word = imem[pc[AW+1:2]];
  assign target_pc  = redirect_pc & ~DATA_W'(3);

  assign d_valid = (count != '0);
  assign pop     = d_valid & ~stall;
  // A full queue may still accept a new word when the head leaves in the
  // same cycle; a redirect suppresses fetch on its edge.
  assign push    = ~redirect & ((count < CW'(QDEPTH)) | pop);

  // Head outputs come straight from storage; nothing bypasses from imem,
  // so a freshly fetched word is seen one edge after it is pushed.
  assign d_inst  = d_valid ? inst_q[rd_ptr] : '0;
  assign d_pc    = d_valid ? pc4_q[rd_ptr]  : '0;
  assign q_count = count;

  // Instruction memory write port. The fetch read above is combinational
  // from the current contents, so a same-cycle write to the fetched word
  // delivers the old value. Reset does not clear the memory.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem[imem_waddr] <= imem_wdata;
    end
  end

  // Queue storage needs no reset: entries are only read while counted.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      inst_q[wr_ptr] <= fetch_word;
      pc4_q[wr_ptr]  <= pc_plus4;
    end
  end

  // PC, pointers and occupancy. Priority: reset, then redirect flush,
  // then normal push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      pc     <= target_pc;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc     <= pc_plus4;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit
//
// Self-checking bench for fetch_queue_unit (DATA_W=32, IMEM_DEPTH=32,
// QDEPTH=4, RESET_PC=0). A table of directed vectors with constant
// expectations covers the startup stream, stall fill/drain, redirect
// flush, reset priority and address wrap; a short hand-written sequence
// covers imem read-before-write; a random phase compares against a
// queue-based reference model of the fetch stage.
module tb_fetch_queue_unit;

  localparam int DATA_W     = 32;
  localparam int IMEM_DEPTH = 32;
  localparam int QDEPTH     = 4;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_we;
  logic [4:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        d_valid;
  logic [31:0] d_inst;
  logic [31:0] d_pc;
  logic [2:0]  q_count;

  int checks   = 0;
  int failures = 0;

  fetch_queue_unit #(
    .DATA_W     (DATA_W),
    .IMEM_DEPTH (IMEM_DEPTH),
    .QDEPTH     (QDEPTH),
    .RESET_PC   (32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_we     (imem_we),
    .imem_waddr  (imem_waddr),
    .imem_wdata  (imem_wdata),
    .d_valid     (d_valid),
    .d_inst      (d_inst),
    .d_pc        (d_pc),
    .q_count     (q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain queue of {instruction, pc+4} plus a pc and a
  // memory image, advanced once per clock edge.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } entry_t;

  entry_t      mq[$];
  logic [31:0] mpc;
  logic [31:0] mmem [IMEM_DEPTH];

  typedef struct {
    string       name;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] ei;
    logic [31:0] ep;
    logic [2:0]  ec;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] initWord(input int i);
    case (i)
      0:       return 32'h00000000;
      1:       return 32'h200a0005;
      2:       return 32'h200b0007;
      3:       return 32'h200c0002;
      default: return 32'h10000000 + 32'(i);
    endcase
  endfunction

  task automatic modelStep(input logic r, input logic s, input logic red,
                           input logic [31:0] rpc, input logic we,
                           input logic [4:0] wa, input logic [31:0] wd);
    logic [31:0] fetched;
    bit          p_pop;
    bit          p_push;
    fetched = mmem[(mpc >> 2) % IMEM_DEPTH];
    if (r) begin
      mpc = 32'h0;
      mq.delete();
    end else if (red) begin
      mq.delete();
      mpc = {rpc[31:2], 2'b00};
    end else begin
      p_pop  = (mq.size() > 0) && !s;
      p_push = (mq.size() < QDEPTH) || p_pop;
      if (p_pop) void'(mq.pop_front());
      if (p_push) begin
        mq.push_back('{inst: fetched, pc4: mpc + 32'd4});
        mpc = mpc + 32'd4;
      end
    end
    if (we) mmem[wa] = wd;
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic red,
                               input logic [31:0] rpc, input logic we,
                               input logic [4:0] wa, input logic [31:0] wd);
    rst         = r;
    stall       = s;
    redirect    = red;
    redirect_pc = rpc;
    imem_we     = we;
    imem_waddr  = wa;
    imem_wdata  = wd;
    modelStep(r, s, red, rpc, we, wa, wd);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic ev,
                             input logic [31:0] ei, input logic [31:0] ep,
                             input logic [2:0] ec);
    checks++;
    if (d_valid !== ev || d_inst !== ei || d_pc !== ep || q_count !== ec) begin
      failures++;
      $display("[TB] FAIL %s: got valid=%0b inst=%h pc=%h count=%0d, expected valid=%0b inst=%h pc=%h count=%0d",
               name, d_valid, d_inst, d_pc, q_count, ev, ei, ep, ec);
    end
  endtask

  task automatic checkModel(input string name);
    logic        ev;
    logic [31:0] ei;
    logic [31:0] ep;
    ev = (mq.size() > 0);
    ei = ev ? mq[0].inst : 32'h0;
    ep = ev ? mq[0].pc4  : 32'h0;
    checkOutput(name, ev, ei, ep, 3'(mq.size()));
  endtask

  task automatic addVec(input string n, input logic r, input logic s,
                        input logic red, input logic [31:0] rpc,
                        input logic ev, input logic [31:0] ei,
                        input logic [31:0] ep, input logic [2:0] ec);
    vec_t v;
    v.name = n; v.rst = r; v.stall = s; v.redirect = red; v.rpc = rpc;
    v.ev = ev; v.ei = ei; v.ep = ep; v.ec = ec;
    vecs.push_back(v);
  endtask

  initial begin
    mpc = 32'h0;
    for (int i = 0; i < IMEM_DEPTH; i++) mmem[i] = 32'hx;

    // Directed table: each row is applied for one edge, then checked.
    addVec("start_c1",     0, 0, 0, 32'h0,        1, 32'h00000000, 32'd4,     3'd1);
    addVec("start_c2",     0, 0, 0, 32'h0,        1, 32'h200a0005, 32'd8,     3'd1);
    addVec("start_c3",     0, 0, 0, 32'h0,        1, 32'h200b0007, 32'd12,    3'd1);
    addVec("start_c4",     0, 0, 0, 32'h0,        1, 32'h200c0002, 32'd16,    3'd1);
    addVec("rst_a",        1, 0, 0, 32'h0,        0, 32'h0,        32'h0,     3'd0);
    addVec("stall_1",      0, 1, 0, 32'h0,        1, 32'h00000000, 32'd4,     3'd1);
    addVec("stall_2",      0, 1, 0, 32'h0,        1, 32'h00000000, 32'd4,     3'd2);
    addVec("stall_3",      0, 1, 0, 32'h0,        1, 32'h00000000, 32'd4,     3'd3);
    addVec("stall_4",      0, 1, 0, 32'h0,        1, 32'h00000000, 32'd4,     3'd4);
    addVec("stall_5",      0, 1, 0, 32'h0,        1, 32'h00000000, 32'd4,     3'd4);
    addVec("stall_6",      0, 1, 0, 32'h0,        1, 32'h00000000, 32'd4,     3'd4);
    addVec("drain_1",      0, 0, 0, 32'h0,        1, 32'h200a0005, 32'd8,     3'd4);
    addVec("drain_2",      0, 0, 0, 32'h0,        1, 32'h200b0007, 32'd12,    3'd4);
    addVec("drain_3",      0, 0, 0, 32'h0,        1, 32'h200c0002, 32'd16,    3'd4);
    addVec("drain_4",      0, 0, 0, 32'h0,        1, 32'h10000004, 32'd20,    3'd4);
    addVec("rst_b",        1, 0, 0, 32'h0,        0, 32'h0,        32'h0,     3'd0);
    addVec("fill_1",       0, 1, 0, 32'h0,        1, 32'h00000000, 32'd4,     3'd1);
    addVec("fill_2",       0, 1, 0, 32'h0,        1, 32'h00000000, 32'd4,     3'd2);
    addVec("fill_3",       0, 1, 0, 32'h0,        1, 32'h00000000, 32'd4,     3'd3);
    addVec("redir_flush",  0, 0, 1, 32'h0000000E, 0, 32'h0,        32'h0,     3'd0);
    addVec("redir_target", 0, 0, 0, 32'h0,        1, 32'h200c0002, 32'h10,    3'd1);
    addVec("rst_redir",    1, 0, 1, 32'h00000040, 0, 32'h0,        32'h0,     3'd0);
    addVec("rst_redir_pc", 0, 0, 0, 32'h0,        1, 32'h00000000, 32'd4,     3'd1);
    addVec("pre_stall",    0, 1, 0, 32'h0,        1, 32'h00000000, 32'd4,     3'd2);
    addVec("redir_stall",  0, 1, 1, 32'h00000008, 0, 32'h0,        32'h0,     3'd0);
    addVec("redir_stall2", 0, 0, 0, 32'h0,        1, 32'h200b0007, 32'd12,    3'd1);
    addVec("wrap_redir",   0, 0, 1, 32'h000000FC, 0, 32'h0,        32'h0,     3'd0);
    addVec("wrap_31",      0, 0, 0, 32'h0,        1, 32'h1000001F, 32'h100,   3'd1);
    addVec("wrap_0",       0, 0, 0, 32'h0,        1, 32'h00000000, 32'h104,   3'd1);
    addVec("pcovf_redir",  0, 0, 1, 32'hFFFFFFFC, 0, 32'h0,        32'h0,     3'd0);
    addVec("pcovf_top",    0, 0, 0, 32'h0,        1, 32'h1000001F, 32'h0,     3'd1);
    addVec("pcovf_zero",   0, 0, 0, 32'h0,        1, 32'h00000000, 32'd4,     3'd1);

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_we = 1'b0; imem_waddr = 5'd0; imem_wdata = 32'h0;

    // Load instruction memory while held in reset.
    for (int i = 0; i < IMEM_DEPTH; i++) begin
      applyStimulus(1, 0, 0, 32'h0, 1, 5'(i), initWord(i));
    end
    applyStimulus(1, 0, 0, 32'h0, 0, 5'd0, 32'h0);
    checkOutput("reset_state", 0, 32'h0, 32'h0, 3'd0);

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].rst, vecs[k].stall, vecs[k].redirect, vecs[k].rpc,
                    0, 5'd0, 32'h0);
      checkOutput(vecs[k].name, vecs[k].ev, vecs[k].ei, vecs[k].ep, vecs[k].ec);
    end

    // Same-cycle write to the word being fetched: old word first, new
    // word on the next fetch of that address.
    applyStimulus(0, 0, 1, 32'h00000020, 0, 5'd0, 32'h0);
    checkOutput("wr_redirect", 0, 32'h0, 32'h0, 3'd0);
    applyStimulus(0, 0, 0, 32'h0, 1, 5'd8, 32'hDEADBEEF);
    checkOutput("wr_old_word", 1, 32'h10000008, 32'h24, 3'd1);
    applyStimulus(0, 1, 1, 32'h00000020, 0, 5'd0, 32'h0);
    checkOutput("wr_reredirect", 0, 32'h0, 32'h0, 3'd0);
    applyStimulus(0, 0, 0, 32'h0, 0, 5'd0, 32'h0);
    checkOutput("wr_new_word", 1, 32'hDEADBEEF, 32'h24, 3'd1);

    // Random traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      logic        r;
      logic        s;
      logic        red;
      logic [31:0] rpc;
      logic        we;
      r   = ($urandom_range(0, 49) == 0);
      s   = ($urandom_range(0, 9) < 4);
      red = ($urandom_range(0, 9) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 200));
      we  = ($urandom_range(0, 4) == 0);
      applyStimulus(r, s, red, rpc, we, 5'($urandom_range(0, 31)), 32'($urandom));
      checkModel("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
